// File: rtl/rv_ctrl_pkg.sv
// Shared opcode, ALU-operation and FSM encodings for the fetch/control sequencer.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_IALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic       alu_src;
        logic [3:0] alu_op;
        logic       mem_to_reg;
        logic       is_load;
        logic       is_store;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

    // Shared funct3 mapping; sub is the only case where funct7 changes the result.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder; the sequencer registers its result in DECODE.
module ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSN = 32'h0000_0073
) (
    input  logic [31:0] insn_i,
    output dec_t        dec_o
);

    always_comb begin
        dec_o = '0;
        if (insn_i == HALT_INSN) begin
            dec_o.is_halt = 1'b1;
        end else begin
            case (insn_i[6:0])
                OPC_RTYPE: begin
                    dec_o.alu_op = (insn_i[30] && insn_i[14:12] == 3'b000) ? ALU_SUB
                                                                           : alu_from_funct3(insn_i[14:12]);
                end
                OPC_IALU: begin
                    dec_o.alu_src = 1'b1;
                    dec_o.alu_op  = alu_from_funct3(insn_i[14:12]);
                end
                OPC_LOAD: begin
                    dec_o.alu_src    = 1'b1;
                    dec_o.alu_op     = ALU_ADD;
                    dec_o.mem_to_reg = 1'b1;
                    dec_o.is_load    = 1'b1;
                end
                OPC_STORE: begin
                    dec_o.alu_src  = 1'b1;
                    dec_o.alu_op   = ALU_ADD;
                    dec_o.is_store = 1'b1;
                end
                default: dec_o.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl_seq.sv
// PC, instruction memory and multi-cycle control FSM feeding the single-issue datapath.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_ctrl_seq
    import rv_ctrl_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN  = 32'h0000_0073,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   instruction,
    output logic          RegWrite,
    output logic          ALUSrc,
    output logic [3:0]    ALUop,
    output logic          MemWrite,
    output logic          MemRead,
    output logic          MemtoReg,
    output logic [31:0]   pc,
    output logic          busy,
    output logic          halted,
    output logic          illegal
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   cycle_cnt,
    output logic [31:0]   retire_cnt
`endif
);

    logic [31:0] imem [IMEM_DEPTH];

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;
    logic        alu_src_q, alu_src_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        is_load_q, is_load_d;
    logic        is_store_q, is_store_d;
    logic        illegal_q, illegal_d;
    dec_t        dec;

    ctrl_decode #(.HALT_INSN(HALT_INSN)) u_decode (
        .insn_i (insn_q),
        .dec_o  (dec)
    );

    // Preload port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        alu_src_d    = alu_src_q;
        alu_op_d     = alu_op_q;
        mem_to_reg_d = mem_to_reg_q;
        is_load_d    = is_load_q;
        is_store_d   = is_store_q;
        illegal_d    = 1'b0;
        if (!(stall && busy)) begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_FETCH;
                ST_FETCH: begin
                    insn_d  = imem[pc_q[AW+1:2]];
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (dec.is_halt) begin
                        state_d = ST_HALT;
                    end else if (dec.is_illegal) begin
                        illegal_d = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = ST_FETCH;
                    end else begin
                        alu_src_d    = dec.alu_src;
                        alu_op_d     = dec.alu_op;
                        mem_to_reg_d = dec.mem_to_reg;
                        is_load_d    = dec.is_load;
                        is_store_d   = dec.is_store;
                        state_d      = ST_EXEC;
                    end
                end
                ST_EXEC:  state_d = (is_load_q || is_store_q) ? ST_MEM : ST_WB;
                ST_MEM: begin
                    if (is_store_q) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_WB: begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_FETCH;
                end
                default:  state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            insn_q       <= '0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
            mem_to_reg_q <= 1'b0;
            is_load_q    <= 1'b0;
            is_store_q   <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            mem_to_reg_q <= mem_to_reg_d;
            is_load_q    <= is_load_d;
            is_store_q   <= is_store_d;
            illegal_q    <= illegal_d;
        end
    end

    // Enables decode straight from the state register so reset clears them asynchronously.
    assign RegWrite    = (state_q == ST_WB);
    assign MemWrite    = (state_q == ST_MEM) && is_store_q;
    assign MemRead     = ((state_q == ST_MEM) || (state_q == ST_WB)) && is_load_q;
    assign ALUSrc      = alu_src_q;
    assign ALUop       = alu_op_q;
    assign MemtoReg    = mem_to_reg_q;
    assign instruction = insn_q;
    assign pc          = pc_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign illegal     = illegal_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cycle_q, retire_q;
    logic        retire;

    assign retire = !stall && ((state_q == ST_WB) || (state_q == ST_MEM && is_store_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (busy)   cycle_q  <= cycle_q + 32'd1;
            if (retire) retire_q <= retire_q + 32'd1;
        end
    end

    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
`endif

endmodule

// File: doc/fetch_ctrl_seq.md
Name: fetch_ctrl_seq

Overview:
- Upstream stage of the single-issue RISC-V datapath (`main`).
- Holds the PC and a small instruction memory.
- Fetches one instruction at a time and steps a multi-cycle control FSM.
- Drives the datapath's `instruction`, RegWrite, ALUSrc, ALUop, MemWrite, MemRead and MemtoReg inputs with per-state timing, so the datapath sees correctly sequenced controls.

Parameters:
IMEM_DEPTH, 64, number of 32-bit instruction words (power of two)
RESET_PC, 32'h0000_0000, PC value after reset
HALT_INSN, 32'h0000_0073, encoding (ECALL) that stops sequencing

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  pulse: begin sequencing from current PC (IDLE only)
stall  input  1  datapath hold; FSM freezes in current state
imem_we  input  1  instruction memory write strobe
imem_waddr  input  log2(IMEM_DEPTH)  word address for preload
imem_wdata  input  32  preload data
instruction  output  32  instruction register to datapath
RegWrite  output  1  register-file write enable
ALUSrc  output  1  0 = rs2, 1 = immediate
ALUop  output  4  ALU operation code
MemWrite  output  1  data-memory write enable
MemRead  output  1  data-memory read enable
MemtoReg  output  1  writeback source: 1 = memory, 0 = ALU
pc  output  32  current PC
busy  output  1  high in any state except IDLE and HALT
halted  output  1  high in HALT
illegal  output  1  one-cycle pulse on unsupported opcode

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- On reset:
  - state = IDLE, pc = RESET_PC, instruction = 0.
  - All control outputs = 0; busy, halted and illegal = 0.
  - Instruction memory contents are not reset.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - start=1 → FETCH.
  - start is ignored in every other state.
- FETCH:
  - instruction <= imem[pc[log2(IMEM_DEPTH)+1:2]]; the word index wraps modulo IMEM_DEPTH.
  - All enables = 0.
  - → DECODE.
- DECODE: register the class-level controls from instruction[6:0]:
  - 0110011 R-type: ALUSrc=0, MemtoReg=0. ALUop from {funct7[5], funct3}: add 0010, sub 0110, and 0000, or 0001, xor 0011, sll 0100, srl 0101, slt 0111.
  - 0010011 I-ALU: ALUSrc=1, MemtoReg=0. ALUop from funct3 as above; funct7[5] is ignored except for srai, which maps to 0101.
  - 0000011 load: ALUSrc=1, ALUop=0010, MemtoReg=1.
  - 0100011 store: ALUSrc=1, ALUop=0010.
  - instruction == HALT_INSN → HALT.
  - Any other opcode: illegal pulses for 1 cycle, pc += 4, → FETCH.
  - Legal opcode → EXEC.
- EXEC:
  - Controls held stable.
  - Load or store → MEM; otherwise → WB.
- MEM:
  - Store: MemWrite=1 for exactly one cycle, then pc += 4 → FETCH.
  - Load: MemRead=1, → WB.
- WB:
  - RegWrite=1 for exactly one cycle.
  - Load: MemRead also held high here.
  - pc += 4 → FETCH.
- Enable rule: RegWrite, MemWrite and MemRead are 0 outside the states listed above. ALUSrc, ALUop, MemtoReg and instruction hold their values from DECODE until the next FETCH.
- Latency:
  - R-type / I-ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Store: 4 cycles.
  - Load: 5 cycles.
- Stall:
  - In FETCH through WB, stall=1 holds state, pc and all outputs unchanged, including a held RegWrite or MemWrite.
  - The datapath must tolerate a repeated write to the same address.
  - stall has no effect in IDLE or HALT.
- pc arithmetic is 32-bit modulo and wraps 0xFFFF_FFFC → 0.
- HALT: terminal until rst. halted=1, all enables = 0.
- Instruction memory write:
  - imem_we writes on the clock edge in any state.
  - A write to the address being fetched in the same cycle: FETCH returns the old word (read-before-write).
- Reset asserted mid-operation aborts immediately; no partial write enable survives.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds 32-bit outputs cycle_cnt and retire_cnt, both reset to 0 and wrapping.
  - cycle_cnt increments every cycle while busy=1.
  - retire_cnt increments on each WB→FETCH transition and on each store MEM→FETCH transition; stalled cycles do not retire.
- When undefined: the ports and logic are absent and the port list is otherwise identical.

Decomposition:
- Shared package `rv_ctrl_pkg`:
  - Opcode constants: OPC_RTYPE, OPC_IALU, OPC_LOAD, OPC_STORE.
  - ALUop constants: ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, etc.
  - FSM state encoding.
- One sub-module, `ctrl_decode`: a combinational opcode/funct → {ALUSrc, ALUop, MemtoReg, is_load, is_store, is_halt, is_illegal}, registered by the FSM in DECODE.

Test Plan:
- Preload imem[0] = 32'h0011_8433 (add x8,x3,x1), then pulse start.
  - DECODE result: ALUSrc=0, ALUop=0010, MemtoReg=0.
  - RegWrite=1 only in the 4th cycle after start; pc then = 4.
- Preload lw 0x0000_A303 at word 0 and sw 0x0060_A223 at word 1, then run.
  - Load: MemRead high in MEM and WB, RegWrite in WB, total 5 cycles.
  - Store: MemWrite exactly 1 cycle, RegWrite never set; pc = 8.
- Hold stall=1 for 3 cycles during WB of an add.
  - RegWrite stays 1 for 4 cycles total; pc advances only once.
- Preload word 0 = 32'hFFFF_FFFF.
  - illegal pulses once, no enables assert, pc = 4, next FETCH proceeds.
- Preload word 2 = 32'h0000_0073 after two adds.
  - halted=1 and busy=0 after the 2nd add, pc = 8.
  - A subsequent start is ignored.
  - rst → state IDLE, pc = 0.
- Assert rst during MEM of a store.
  - MemWrite drops to 0 asynchronously (before the next clk edge).
  - pc = RESET_PC; busy = 0.
